// File: rtl/sc_pkg.sv
// Shared definitions for the sc_ processor front end: PC-source codes and IFU state encoding.
package sc_pkg;

    localparam logic [1:0] PCSRC_SEQ = 2'd0;
    localparam logic [1:0] PCSRC_BR  = 2'd1;
    localparam logic [1:0] PCSRC_JR  = 2'd2;
    localparam logic [1:0] PCSRC_J   = 2'd3;

    typedef enum logic [1:0] {
        IFU_IDLE  = 2'd0,
        IFU_FETCH = 2'd1,
        IFU_VALID = 2'd2,
        IFU_HALT  = 2'd3
    } ifu_state_t;

    // Sign-extended, word-scaled branch displacement.
    function automatic logic [31:0] br_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/sc_npc.sv
// Next-PC selection and jr-target alignment check; purely combinational.
module sc_npc
    import sc_pkg::*;
(
    input  logic [1:0]  pcsource,
    input  logic [31:0] pc4,
    input  logic [25:0] inst_low,
    input  logic [31:0] ra_data,
    output logic [31:0] next_pc,
    output logic        misalign
);

    always_comb begin
        next_pc  = pc4;
        misalign = 1'b0;
        case (pcsource)
            PCSRC_SEQ: next_pc = pc4;
            PCSRC_BR:  next_pc = pc4 + br_offset(inst_low[15:0]);
            PCSRC_JR: begin
                next_pc  = ra_data;
                misalign = (ra_data[1:0] != 2'b00);
            end
            PCSRC_J:   next_pc = {pc4[31:28], inst_low, 2'b00};
            default:   next_pc = pc4;
        endcase
    end

endmodule

// File: rtl/sc_ifu.sv
// Instruction-fetch unit: PC/IR registers, imem request handshake, fetch timeout and next-PC update at retire.
module sc_ifu
    import sc_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [15:0] TIMEOUT_CYC = 16'd255
)(
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  pcsource,
    input  logic [31:0] ra_data,
    input  logic        retire,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        fault,
    output logic [31:0] fetch_cnt
);

    ifu_state_t  state_reg;
    logic [31:0] pc_reg;
    logic [31:0] inst_reg;
    logic        inst_valid_reg;
    logic        imem_req_reg;
    logic        fault_reg;
    logic [31:0] fetch_cnt_reg;
    logic [15:0] timer_reg;

    logic [31:0] pc4_next;
    logic [31:0] npc_next;
    logic        npc_misalign;
    logic [15:0] timer_next;

    assign pc4_next   = pc_reg + 32'd4;
    assign timer_next = timer_reg + 16'd1;

    sc_npc u_npc (
        .pcsource (pcsource),
        .pc4      (pc4_next),
        .inst_low (inst_reg[25:0]),
        .ra_data  (ra_data),
        .next_pc  (npc_next),
        .misalign (npc_misalign)
    );

    // imem_req is set on the edge that enters FETCH, so it is high for the whole FETCH stay.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= IFU_IDLE;
            pc_reg         <= RESET_PC;
            inst_reg       <= 32'd0;
            inst_valid_reg <= 1'b0;
            imem_req_reg   <= 1'b0;
            fault_reg      <= 1'b0;
            fetch_cnt_reg  <= 32'd0;
            timer_reg      <= 16'd0;
        end else begin
            case (state_reg)
                IFU_IDLE: begin
                    state_reg    <= IFU_FETCH;
                    imem_req_reg <= 1'b1;
                end
                IFU_FETCH: begin
                    if (imem_ready) begin
                        inst_reg       <= imem_rdata;
                        inst_valid_reg <= 1'b1;
                        fetch_cnt_reg  <= fetch_cnt_reg + 32'd1;
                        timer_reg      <= 16'd0;
                        imem_req_reg   <= 1'b0;
                        state_reg      <= IFU_VALID;
                    end else begin
                        timer_reg <= timer_next;
                        if (timer_next == TIMEOUT_CYC) begin
                            fault_reg    <= 1'b1;
                            imem_req_reg <= 1'b0;
                            state_reg    <= IFU_HALT;
                        end
                    end
                end
                IFU_VALID: begin
                    if (retire) begin
                        inst_valid_reg <= 1'b0;
                        if (npc_misalign) begin
                            fault_reg <= 1'b1;
                            state_reg <= IFU_HALT;
                        end else begin
                            pc_reg       <= npc_next;
                            imem_req_reg <= 1'b1;
                            state_reg    <= IFU_FETCH;
                        end
                    end
                end
                IFU_HALT: begin
                    inst_valid_reg <= 1'b0;
                    imem_req_reg   <= 1'b0;
                end
                default: state_reg <= IFU_IDLE;
            endcase
        end
    end

    assign imem_req   = imem_req_reg;
    assign imem_addr  = pc_reg;
    assign inst       = inst_reg;
    assign inst_valid = inst_valid_reg;
    assign pc         = pc_reg;
    assign pc4        = pc4_next;
    assign fault      = fault_reg;
    assign fetch_cnt  = fetch_cnt_reg;

endmodule

// File: tb/tb_sc_ifu.sv
// Directed bench for sc_ifu: sequential fetch, branch, jal, jr, timeout, reset and PC wrap scenarios.
module tb_sc_ifu;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  pcsource;
    logic [31:0] ra_data;
    logic        retire;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        fault;
    logic [31:0] fetch_cnt;

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_cnt      = 0;

    always #5 clock = ~clock;

    sc_ifu #(
        .RESET_PC    (32'h0000_0000),
        .TIMEOUT_CYC (16'd4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .pcsource   (pcsource),
        .ra_data    (ra_data),
        .retire     (retire),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .inst       (inst),
        .inst_valid (inst_valid),
        .pc         (pc),
        .pc4        (pc4),
        .fault      (fault),
        .fetch_cnt  (fetch_cnt)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!imem_req && n < 10) begin
            tick();
            n++;
        end
        tests_run++;
        if (imem_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s: imem_req got %b want 1 within 10 cycles", name, imem_req);
        end
    endtask

    task automatic serve(input logic [31:0] data);
        imem_rdata = data;
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        exp_cnt++;
    endtask

    task automatic do_retire(input logic [1:0] src, input logic [31:0] ra);
        pcsource = src;
        ra_data  = ra;
        retire   = 1'b1;
        tick();
        retire   = 1'b0;
    endtask

    // Fetch a filler word at the current PC then jr to target.
    task automatic jump_to(input logic [31:0] target);
        wait_req("jump_to_req");
        serve(32'h0000_0000);
        do_retire(2'b10, target);
    endtask

    task automatic test_reset();
        apply_reset();
        reset = 1'b1;
        tick();
        tests_run++;
        if ({imem_req, inst_valid, fault} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_flags: req/valid/fault got %b want 000", {imem_req, inst_valid, fault});
        end
        tests_run++;
        if (pc !== 32'h0 || inst !== 32'h0 || fetch_cnt !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_regs: pc %h inst %h cnt %0d want 0 0 0", pc, inst, fetch_cnt);
        end
        reset = 1'b0;
        tick();
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            tests_failed++;
            $display("FAIL idle_to_fetch: req %b addr %h want 1 00000000", imem_req, imem_addr);
        end
        $display("[TB] reset: pc=%h req=%b", pc, imem_req);
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            wait_req("seq_req");
            tests_run++;
            if (imem_addr !== 32'(4 * i)) begin
                tests_failed++;
                $display("FAIL seq_addr%0d: got %h want %h", i, imem_addr, 32'(4 * i));
            end
            serve(32'hA000_0000 + 32'(i));
            tests_run++;
            if (inst_valid !== 1'b1 || inst !== 32'hA000_0000 + 32'(i) || pc4 !== 32'(4 * i + 4)) begin
                tests_failed++;
                $display("FAIL seq_valid%0d: valid %b inst %h pc4 %h want 1 %h %h",
                         i, inst_valid, inst, pc4, 32'hA000_0000 + 32'(i), 32'(4 * i + 4));
            end
            do_retire(2'b00, 32'h0);
            $display("[TB] seq fetch %0d addr=%h", i, 32'(4 * i));
        end
        tests_run++;
        if (fetch_cnt !== 32'd3) begin
            tests_failed++;
            $display("FAIL seq_cnt: got %0d want 3", fetch_cnt);
        end
    endtask

    task automatic test_branch();
        jump_to(32'h0000_0100);
        wait_req("br_req");
        tests_run++;
        if (imem_addr !== 32'h0000_0100) begin
            tests_failed++;
            $display("FAIL br_jr_addr: got %h want 00000100", imem_addr);
        end
        serve(32'h1000_FFFF);
        do_retire(2'b01, 32'h0);
        wait_req("br_req2");
        tests_run++;
        if (imem_addr !== 32'h0000_0100) begin
            tests_failed++;
            $display("FAIL br_target: got %h want 00000100", imem_addr);
        end
        $display("[TB] branch: target=%h", imem_addr);
    endtask

    task automatic test_jal();
        jump_to(32'h8000_0010);
        wait_req("jal_req");
        serve(32'h0C00_0040);
        tests_run++;
        if (pc4 !== 32'h8000_0014 || pc !== 32'h8000_0010) begin
            tests_failed++;
            $display("FAIL jal_pc4: pc %h pc4 %h want 80000010 80000014", pc, pc4);
        end
        do_retire(2'b11, 32'h0);
        wait_req("jal_req2");
        tests_run++;
        if (imem_addr !== 32'h8000_0100) begin
            tests_failed++;
            $display("FAIL jal_target: got %h want 80000100", imem_addr);
        end
        $display("[TB] jal: target=%h", imem_addr);
    endtask

    task automatic test_wrap();
        jump_to(32'hFFFF_FFFC);
        wait_req("wrap_req");
        serve(32'h0000_0000);
        tests_run++;
        if (pc4 !== 32'h0) begin
            tests_failed++;
            $display("FAIL wrap_pc4: got %h want 00000000", pc4);
        end
        do_retire(2'b00, 32'h0);
        wait_req("wrap_req2");
        tests_run++;
        if (imem_addr !== 32'h0 || fault !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_next: addr %h fault %b want 00000000 0", imem_addr, fault);
        end
        $display("[TB] wrap: addr=%h fault=%b", imem_addr, fault);
    endtask

    task automatic test_retire_in_fetch();
        // Currently in FETCH at address 0; retire here must be ignored.
        pcsource = 2'b10;
        ra_data  = 32'h0000_4000;
        retire   = 1'b1;
        tick();
        tick();
        retire   = 1'b0;
        tests_run++;
        if (pc !== 32'h0 || imem_req !== 1'b1 || inst_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL retire_in_fetch: pc %h req %b valid %b want 00000000 1 0", pc, imem_req, inst_valid);
        end
        serve(32'h0000_0000);
        tests_run++;
        if (fetch_cnt !== 32'(exp_cnt)) begin
            tests_failed++;
            $display("FAIL fetch_cnt: got %0d want %0d", fetch_cnt, exp_cnt);
        end
        $display("[TB] retire in fetch: pc=%h cnt=%0d", pc, fetch_cnt);
    endtask

    task automatic test_jr_misalign();
        // In VALID at pc 0 from the previous scenario.
        do_retire(2'b10, 32'h0000_2002);
        tests_run++;
        if (fault !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0 || pc !== 32'h0) begin
            tests_failed++;
            $display("FAIL jr_misalign: fault %b req %b valid %b pc %h want 1 0 0 00000000",
                     fault, imem_req, inst_valid, pc);
        end
        do_retire(2'b00, 32'h0);
        tick();
        tick();
        tests_run++;
        if (fault !== 1'b1 || imem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL halt_sticky: fault %b req %b want 1 0", fault, imem_req);
        end
        $display("[TB] jr misalign: fault=%b", fault);
    endtask

    task automatic test_jr_aligned();
        apply_reset();
        tick();
        jump_to(32'h0000_2000);
        wait_req("jr_req");
        tests_run++;
        if (imem_addr !== 32'h0000_2000) begin
            tests_failed++;
            $display("FAIL jr_target: got %h want 00002000", imem_addr);
        end
        $display("[TB] jr: target=%h", imem_addr);
    endtask

    task automatic test_timeout();
        apply_reset();
        tick();
        for (int i = 1; i <= 3; i++) begin
            tick();
            tests_run++;
            if (fault !== 1'b0 || imem_req !== 1'b1) begin
                tests_failed++;
                $display("FAIL timeout_early%0d: fault %b req %b want 0 1", i, fault, imem_req);
            end
        end
        tick();
        tests_run++;
        if (fault !== 1'b1 || imem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout: fault %b req %b want 1 0", fault, imem_req);
        end
        $display("[TB] timeout: fault=%b", fault);
    endtask

    task automatic test_reset_mid_fetch();
        apply_reset();
        tick();
        imem_rdata = 32'hDEAD_BEEF;
        imem_ready = 1'b1;
        reset      = 1'b1;
        tick();
        imem_ready = 1'b0;
        reset      = 1'b0;
        tests_run++;
        if (inst_valid !== 1'b0 || pc !== 32'h0 || inst !== 32'h0 || fetch_cnt !== 32'h0 || fault !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_fetch: valid %b pc %h inst %h cnt %0d fault %b want 0 0 0 0 0",
                     inst_valid, pc, inst, fetch_cnt, fault);
        end
        $display("[TB] reset mid fetch: valid=%b pc=%h", inst_valid, pc);
    endtask

    initial begin
        reset      = 1'b1;
        pcsource   = 2'b00;
        ra_data    = 32'h0;
        retire     = 1'b0;
        imem_rdata = 32'h0;
        imem_ready = 1'b0;
        test_reset();
        test_sequential();
        test_branch();
        test_jal();
        test_wrap();
        test_retire_in_fetch();
        test_jr_misalign();
        test_jr_aligned();
        test_timeout();
        test_reset_mid_fetch();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
